fpu_minmax_reduce: RTL and testbench

Sequential reduction engine for vector FMIN/FMAX over a stream of recoded FP operands. It accepts a command carrying the length and the operation, then consumes that many elements one per cycle. It folds each element into a running accumulator through a single shared fpu_fmin_fmax instance and returns one recoded result with a sticky invalid flag. It sits beside the vanilla core FPU and is fed by a load/operand streamer.

---
 rtl/fpu_minmax_reduce_pkg.sv | 22 ++
 rtl/fpu_minmax_reduce_fmin_fmax.sv | 64 ++++++
 rtl/fpu_minmax_reduce.sv | 111 +++++++++++
 tb/tb_fpu_minmax_reduce.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_minmax_reduce_pkg.sv
// Shared types and constants for the FMIN/FMAX vector reduction engine.
// Recoded FP layout: {sign, exp[exp_width_p:0], fract[sig_width_p-2:0]}.
package fpu_minmax_reduce_pkg;

    localparam int unsigned ExpWidthDef = 8;
    localparam int unsigned SigWidthDef = 24;
    localparam int unsigned RecWidthDef = ExpWidthDef + SigWidthDef + 1;

    // Canonical quiet NaN for the default widths.
    localparam logic [RecWidthDef-1:0] FPU_RECODED_CANONICAL_NAN = 33'h0_E040_0000;

    // Top three recoded exponent bits classify the operand.
    localparam logic [2:0] RecTopZero = 3'b000;
    localparam logic [2:0] RecTopNaN  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/fpu_minmax_reduce_fmin_fmax.sv
// Combinational FMIN/FMAX on two recoded operands (module fpu_fmin_fmax).
// One NaN operand yields the other; two NaNs yield the canonical NaN; -0 < +0.
module fpu_fmin_fmax
    import fpu_minmax_reduce_pkg::*;
#(
    parameter int unsigned exp_width_p = 8,
    parameter int unsigned sig_width_p = 24
) (
    input  logic [exp_width_p+sig_width_p:0] rs1_i,
    input  logic [exp_width_p+sig_width_p:0] rs2_i,
    input  logic                             fmin_not_fmax_i,
    output logic [exp_width_p+sig_width_p:0] result_o,
    output logic                             invalid_o
);

    localparam int unsigned RecW = exp_width_p + sig_width_p + 1;
    localparam logic [RecW-1:0] CanonNan =
        {1'b0, RecTopNaN, {(exp_width_p-2){1'b0}}, 1'b1, {(sig_width_p-2){1'b0}}};

    logic            a_sign, b_sign;
    logic            a_nan, b_nan;
    logic            a_snan, b_snan;
    logic            a_zero, b_zero;
    logic [RecW-2:0] a_mag, b_mag;
    logic            a_lt_b;

    always_comb begin
        a_sign = rs1_i[RecW-1];
        b_sign = rs2_i[RecW-1];
        a_nan  = (rs1_i[RecW-2 -: 3] == RecTopNaN);
        b_nan  = (rs2_i[RecW-2 -: 3] == RecTopNaN);
        a_snan = a_nan & ~rs1_i[sig_width_p-2];
        b_snan = b_nan & ~rs2_i[sig_width_p-2];
        a_zero = (rs1_i[RecW-2 -: 3] == RecTopZero);
        b_zero = (rs2_i[RecW-2 -: 3] == RecTopZero);

        // Recoded {exp, fract} is monotonic in magnitude once zeros are cleaned.
        a_mag = a_zero ? '0 : rs1_i[RecW-2:0];
        b_mag = b_zero ? '0 : rs2_i[RecW-2:0];

        if (a_sign != b_sign) begin
            a_lt_b = a_sign;
        end else if (a_sign) begin
            a_lt_b = (a_mag > b_mag);
        end else begin
            a_lt_b = (a_mag < b_mag);
        end

        invalid_o = a_snan | b_snan;

        if (a_nan && b_nan) begin
            result_o = CanonNan;
        end else if (a_nan) begin
            result_o = rs2_i;
        end else if (b_nan) begin
            result_o = rs1_i;
        end else if (fmin_not_fmax_i) begin
            result_o = a_lt_b ? rs1_i : rs2_i;
        end else begin
            result_o = a_lt_b ? rs2_i : rs1_i;
        end
    end

endmodule

// File: rtl/fpu_minmax_reduce.sv
// Sequential FMIN/FMAX reduction over a stream of recoded FP elements,
// folding one element per cycle into an accumulator seeded with canonical NaN.
module fpu_minmax_reduce
    import fpu_minmax_reduce_pkg::*;
#(
    parameter int unsigned exp_width_p   = 8,
    parameter int unsigned sig_width_p   = 24,
    parameter int unsigned count_width_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,

    input  logic                             start_v_i,
    output logic                             start_ready_o,
    input  logic                             fmin_not_fmax_i,
    input  logic [count_width_p-1:0]         len_i,

    input  logic                             elem_v_i,
    input  logic [exp_width_p+sig_width_p:0] elem_i,
    output logic                             elem_ready_o,

    output logic                             res_v_o,
    output logic [exp_width_p+sig_width_p:0] res_o,
    output logic                             invalid_o,
    input  logic                             res_yumi_i
);

    localparam int unsigned RecW = exp_width_p + sig_width_p + 1;
    localparam logic [RecW-1:0] CanonNan =
        {1'b0, RecTopNaN, {(exp_width_p-2){1'b0}}, 1'b1, {(sig_width_p-2){1'b0}}};

    state_e                   state_q, state_d;
    logic [RecW-1:0]          acc_q, acc_d;
    logic                     invalid_q, invalid_d;
    logic [count_width_p-1:0] remaining_q, remaining_d;
    logic                     op_q, op_d;

    logic [RecW-1:0]          unit_res;
    logic                     unit_inv;

    fpu_fmin_fmax #(
        .exp_width_p (exp_width_p),
        .sig_width_p (sig_width_p)
    ) u_fmin_fmax (
        .rs1_i           (acc_q),
        .rs2_i           (elem_i),
        .fmin_not_fmax_i (op_q),
        .result_o        (unit_res),
        .invalid_o       (unit_inv)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            acc_q       <= CanonNan;
            invalid_q   <= 1'b0;
            remaining_q <= '0;
            op_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            invalid_q   <= invalid_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        invalid_d   = invalid_q;
        remaining_d = remaining_q;
        op_d        = op_q;

        unique case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    op_d        = fmin_not_fmax_i;
                    remaining_d = len_i;
                    acc_d       = CanonNan;
                    invalid_d   = 1'b0;
                    state_d     = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (elem_v_i) begin
                    acc_d       = unit_res;
                    invalid_d   = invalid_q | unit_inv;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == count_width_p'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; no input-to-output paths.
    assign start_ready_o = (state_q == IDLE);
    assign elem_ready_o  = (state_q == RUN);
    assign res_v_o       = (state_q == DONE);
    assign res_o         = acc_q;
    assign invalid_o     = invalid_q;

endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// Bench for fpu_minmax_reduce: directed scenarios plus randomized vectors checked
// against an IEEE-level reference (ordering key over binary32, then recoded).
module tb_fpu_minmax_reduce;

    localparam logic [32:0] CANON = 33'h0_E040_0000;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_v_i;
    logic        start_ready_o;
    logic        fmin_not_fmax_i;
    logic [15:0] len_i;
    logic        elem_v_i;
    logic [32:0] elem_i;
    logic        elem_ready_o;
    logic        res_v_o;
    logic [32:0] res_o;
    logic        invalid_o;
    logic        res_yumi_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fpu_minmax_reduce #(
        .exp_width_p   (8),
        .sig_width_p   (24),
        .count_width_p (16)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .start_v_i       (start_v_i),
        .start_ready_o   (start_ready_o),
        .fmin_not_fmax_i (fmin_not_fmax_i),
        .len_i           (len_i),
        .elem_v_i        (elem_v_i),
        .elem_i          (elem_i),
        .elem_ready_o    (elem_ready_o),
        .res_v_o         (res_v_o),
        .res_o           (res_o),
        .invalid_o       (invalid_o),
        .res_yumi_i      (res_yumi_i)
    );

    // res_yumi_i is only legal while a result is offered.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && res_yumi_i === 1'b1) begin
            n_cmp++;
            if (res_v_o !== 1'b1) begin
                n_err++;
                $display("FAIL yumi_protocol: res_v_o=%b required 1", res_v_o);
            end
        end
    end

    // IEEE binary32 -> recoded 33-bit.
    function automatic logic [32:0] rec(input logic [31:0] b);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [22:0] fn;
        int          nd;
        bit          found;
        s = b[31];
        e = b[30:23];
        f = b[22:0];
        if (e == 8'h00) begin
            if (f == 23'h0) return {s, 9'h000, 23'h0};
            nd = 0;
            found = 0;
            for (int i = 22; i >= 0; i--) begin
                if (!found && f[i]) begin
                    nd = 22 - i;
                    found = 1;
                end
            end
            fn = f << (nd + 1);
            return {s, 9'(129 - nd), fn};
        end else if (e == 8'hFF) begin
            if (f == 23'h0) return {s, 9'h180, 23'h0};
            return {s, 9'h1C0, f};
        end
        return {s, 9'(int'(e) + 129), f};
    endfunction

    // Total order over non-NaN binary32 values with -0 < +0.
    function automatic longint key(input logic [31:0] b);
        longint mag;
        mag = longint'(b[30:0]);
        return b[31] ? (-mag - 1) : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    endfunction

    // Reduction result = min/max over the non-NaN elements, canonical NaN if none.
    task automatic ref_reduce(input logic op, input logic [31:0] e[$],
                              output logic [32:0] r, output logic inv);
        logic [31:0] best;
        logic [31:0] x;
        bit          have;
        have = 0;
        best = 32'h7FC0_0000;
        inv  = 1'b0;
        foreach (e[i]) begin
            x = e[i];
            if (is_nan(x)) begin
                if (!x[22]) inv = 1'b1;
            end else if (!have || (op ? (key(x) < key(best)) : (key(x) > key(best)))) begin
                best = x;
                have = 1;
            end
        end
        r = rec(best);
    endtask

    function automatic logic [31:0] rand_elem();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 11))
            0:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            1:       return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))};
            2:       return {s, 31'h0};
            3:       return {s, 8'hFF, 23'h0};
            4:       return {s, 8'h00, 23'($urandom_range(1, 8388607))};
            5, 6:    return {s, 8'($urandom_range(126, 128)), 23'($urandom_range(0, 7))};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Drives one command and its elements; reports the first observed result.
    task automatic do_vector(input logic op, input logic [31:0] elems[$],
                             input int bubble_pct, input int yumi_delay, input bit poke_start,
                             output logic [32:0] res, output logic inv, output int lat,
                             output int bad_ready, output int unstable);
        int idx;
        int len;
        len = elems.size();
        bad_ready = 0;
        unstable = 0;
        start_v_i = 1'b1;
        fmin_not_fmax_i = op;
        len_i = 16'(len);
        @(posedge clk_i); #1;
        start_v_i = 1'b0;
        lat = 1;
        idx = 0;
        while (idx < len && lat < 2000) begin
            if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
                elem_v_i = 1'b0;
            end else begin
                elem_v_i = 1'b1;
                elem_i = rec(elems[idx]);
            end
            if (poke_start) begin
                start_v_i = 1'b1;
                len_i = 16'h0007;
                fmin_not_fmax_i = ~op;
            end
            if (elem_ready_o !== 1'b1 || start_ready_o !== 1'b0 || res_v_o !== 1'b0) bad_ready++;
            @(posedge clk_i); #1;
            if (elem_v_i) idx++;
            lat++;
            elem_v_i = 1'b0;
            start_v_i = 1'b0;
            fmin_not_fmax_i = op;
        end
        while (res_v_o !== 1'b1 && lat < 2000) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (elem_ready_o !== 1'b0) bad_ready++;
        res = res_o;
        inv = invalid_o;
        for (int d = 0; d < yumi_delay; d++) begin
            start_v_i = poke_start;
            elem_v_i = 1'b1;
            elem_i = rec(rand_elem());
            @(posedge clk_i); #1;
            if (res_o !== res || invalid_o !== inv || res_v_o !== 1'b1 || start_ready_o !== 1'b0)
                unstable++;
        end
        start_v_i = 1'b0;
        elem_v_i = 1'b0;
        res_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        res_yumi_i = 1'b0;
        if (res_v_o !== 1'b0 || start_ready_o !== 1'b1) unstable++;
    endtask

    task automatic test_reset();
        n_cmp += 5;
        if (start_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_start_ready: got %b want 1", start_ready_o); end
        if (elem_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_elem_ready: got %b want 0", elem_ready_o); end
        if (res_v_o !== 1'b0) begin n_err++; $display("FAIL reset_res_v: got %b want 0", res_v_o); end
        if (res_o !== CANON) begin n_err++; $display("FAIL reset_res: got %h want %h", res_o, CANON); end
        if (invalid_o !== 1'b0) begin n_err++; $display("FAIL reset_invalid: got %b want 0", invalid_o); end
    endtask

    task automatic test_fmax_basic();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        q = '{32'h3F80_0000, 32'hC060_0000, 32'h40E8_0000, 32'h4000_0000};
        do_vector(1'b0, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 5;
        if (r !== rec(32'h40E8_0000)) begin n_err++; $display("FAIL fmax_basic_res: got %h want %h", r, rec(32'h40E8_0000)); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL fmax_basic_inv: got %b want 0", inv); end
        if (lat != 5) begin n_err++; $display("FAIL fmax_basic_latency: got %0d want 5", lat); end
        if (br != 0) begin n_err++; $display("FAIL fmax_basic_ready: got %0d bad cycles want 0", br); end
        if (us != 0) begin n_err++; $display("FAIL fmax_basic_handoff: got %0d bad cycles want 0", us); end
    endtask

    task automatic test_signed_zero();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        q = '{32'h0000_0000, 32'h8000_0000};
        do_vector(1'b1, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 2;
        if (r !== rec(32'h8000_0000)) begin n_err++; $display("FAIL fmin_zero_res: got %h want %h", r, rec(32'h8000_0000)); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL fmin_zero_inv: got %b want 0", inv); end
        do_vector(1'b0, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 2;
        if (r !== rec(32'h0000_0000)) begin n_err++; $display("FAIL fmax_zero_res: got %h want %h", r, rec(32'h0000_0000)); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL fmax_zero_inv: got %b want 0", inv); end
    endtask

    task automatic test_nan_rules();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        q = '{32'h7FC0_0001, 32'h40A0_0000, 32'h7FA0_0000, 32'h4110_0000};
        do_vector(1'b1, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 2;
        if (r !== rec(32'h40A0_0000)) begin n_err++; $display("FAIL nan_fmin_res: got %h want %h", r, rec(32'h40A0_0000)); end
        if (inv !== 1'b1) begin n_err++; $display("FAIL nan_fmin_inv: got %b want 1", inv); end
        q = '{32'h7FA0_0000, 32'h7FC0_0001};
        do_vector(1'b0, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 2;
        if (r !== CANON) begin n_err++; $display("FAIL nan_all_res: got %h want %h", r, CANON); end
        if (inv !== 1'b1) begin n_err++; $display("FAIL nan_all_inv: got %b want 1", inv); end
    endtask

    task automatic test_len_zero();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        q = {};
        do_vector(1'b1, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 4;
        if (r !== CANON) begin n_err++; $display("FAIL len0_res: got %h want %h", r, CANON); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL len0_inv: got %b want 0", inv); end
        if (lat != 1) begin n_err++; $display("FAIL len0_latency: got %0d want 1", lat); end
        if (br != 0) begin n_err++; $display("FAIL len0_elem_ready: got %0d bad cycles want 0", br); end
    endtask

    task automatic test_stress();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        q = '{32'h4080_0000, 32'hBF80_0000, 32'h4000_0000};
        do_vector(1'b1, q, 40, 3, 1'b1, r, inv, lat, br, us);
        n_cmp += 4;
        if (r !== rec(32'hBF80_0000)) begin n_err++; $display("FAIL stress_res: got %h want %h", r, rec(32'hBF80_0000)); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL stress_inv: got %b want 0", inv); end
        if (br != 0) begin n_err++; $display("FAIL stress_busy: got %0d bad cycles want 0", br); end
        if (us != 0) begin n_err++; $display("FAIL stress_hold: got %0d bad cycles want 0", us); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] q[$];
        logic [32:0] r;
        logic inv;
        int lat, br, us;
        start_v_i = 1'b1;
        fmin_not_fmax_i = 1'b0;
        len_i = 16'd5;
        @(posedge clk_i); #1;
        start_v_i = 1'b0;
        elem_v_i = 1'b1;
        elem_i = rec(32'h7FA0_0000);
        @(posedge clk_i); #1;
        elem_i = rec(32'h4120_0000);
        @(posedge clk_i); #1;
        elem_v_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        n_cmp += 5;
        if (res_v_o !== 1'b0) begin n_err++; $display("FAIL midrst_res_v: got %b want 0", res_v_o); end
        if (start_ready_o !== 1'b1) begin n_err++; $display("FAIL midrst_start_ready: got %b want 1", start_ready_o); end
        if (elem_ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_elem_ready: got %b want 0", elem_ready_o); end
        if (res_o !== CANON) begin n_err++; $display("FAIL midrst_res: got %h want %h", res_o, CANON); end
        if (invalid_o !== 1'b0) begin n_err++; $display("FAIL midrst_invalid: got %b want 0", invalid_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        q = '{32'h3F80_0000, 32'h4000_0000};
        do_vector(1'b0, q, 0, 0, 1'b0, r, inv, lat, br, us);
        n_cmp += 3;
        if (r !== rec(32'h4000_0000)) begin n_err++; $display("FAIL midrst_next_res: got %h want %h", r, rec(32'h4000_0000)); end
        if (inv !== 1'b0) begin n_err++; $display("FAIL midrst_next_inv: got %b want 0", inv); end
        if (lat != 3) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [32:0] r, exp_r;
        logic inv, exp_inv;
        logic op;
        int lat, br, us, len, bub;
        for (int v = 0; v < 30; v++) begin
            q = {};
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) q.push_back(rand_elem());
            op = 1'($urandom_range(0, 1));
            bub = (v % 3 == 0) ? 0 : int'($urandom_range(0, 50));
            ref_reduce(op, q, exp_r, exp_inv);
            do_vector(op, q, bub, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      r, inv, lat, br, us);
            n_cmp += 4;
            if (r !== exp_r) begin n_err++; $display("FAIL rand%0d_res: got %h want %h", v, r, exp_r); end
            if (inv !== exp_inv) begin n_err++; $display("FAIL rand%0d_inv: got %b want %b", v, inv, exp_inv); end
            if (br != 0) begin n_err++; $display("FAIL rand%0d_ready: got %0d bad cycles want 0", v, br); end
            if (us != 0) begin n_err++; $display("FAIL rand%0d_hold: got %0d bad cycles want 0", v, us); end
            if (bub == 0) begin
                n_cmp++;
                if (lat != len + 1) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", v, lat, len + 1); end
            end
        end
    endtask

    initial begin
        reset_n_i = 1'b0;
        start_v_i = 1'b0;
        fmin_not_fmax_i = 1'b0;
        len_i = '0;
        elem_v_i = 1'b0;
        elem_i = '0;
        res_yumi_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        test_fmax_basic();
        test_signed_zero();
        test_nan_rules();
        test_len_zero();
        test_stress();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
